comparator_sar_search: RTL and testbench

- Initiator/search engine for the 4-bit magnitude comparator's 6-bit relation vector.
- Holds the comparator's B operand (probe_out) and reads back the flags. Runs a successive-approximation (MSB-first binary) search to recover the unknown value on the comparator's A operand.
- Reports the recovered value plus an error flag if the returned flags are self-inconsistent.
- Sits beside the comparator in the test/measurement datapath.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/comparator_flag_check.sv | 30 +++
 rtl/comparator_sar_search.sv | 130 +++++++++++++
 tb/tb_comparator_sar_search.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude-comparator relation vector and the SAR search engine.
package cmp_pkg;

  localparam int unsigned CMP_FLAGS_W = 6;

  localparam int unsigned FLAG_EQ = 5;
  localparam int unsigned FLAG_NE = 4;
  localparam int unsigned FLAG_GT = 3;
  localparam int unsigned FLAG_LT = 2;
  localparam int unsigned FLAG_GE = 1;
  localparam int unsigned FLAG_LE = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DECIDE,
    DONE
  } state_e;

endpackage

// File: rtl/comparator_flag_check.sv
// Decodes a comparator relation vector into eq/gt/lt and checks it is self-consistent.
module comparator_flag_check
  import cmp_pkg::*;
(
  input  logic [CMP_FLAGS_W-1:0] flags_i,
  output logic                   valid_c,
  output logic                   is_eq_c,
  output logic                   is_gt_c,
  output logic                   is_lt_c
);

  logic eq, ne, gt, lt, ge, le;
  logic one_hot;

  always_comb begin
    eq      = flags_i[FLAG_EQ];
    ne      = flags_i[FLAG_NE];
    gt      = flags_i[FLAG_GT];
    lt      = flags_i[FLAG_LT];
    ge      = flags_i[FLAG_GE];
    le      = flags_i[FLAG_LE];
    one_hot = (eq & ~gt & ~lt) | (~eq & gt & ~lt) | (~eq & ~gt & lt);
    // Redundant flags must agree with the primary eq/gt/lt relation.
    valid_c = (eq ^ ne) & (gt == (ge & ~eq)) & (lt == (le & ~eq)) & one_hot;
    is_eq_c = eq;
    is_gt_c = gt;
    is_lt_c = lt;
  end

endmodule

// File: rtl/comparator_sar_search.sv
// MSB-first successive-approximation search that recovers the comparator's A operand
// by driving trial values on B and reading back the relation flags.
module comparator_sar_search
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CMP_FLAGS_W-1:0] flags_in,
  output logic [WIDTH-1:0]       probe_out,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic                   error
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   probe_q, probe_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [WIDTH-1:0]   res_upd;

  logic valid_c, is_eq_c, is_gt_c, is_lt_c;

  comparator_flag_check u_flag_check (
    .flags_i (flags_in),
    .valid_c (valid_c),
    .is_eq_c (is_eq_c),
    .is_gt_c (is_gt_c),
    .is_lt_c (is_lt_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      result_q <= '0;
      bit_q    <= BIT_W'(WIDTH - 1);
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    res_upd  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = '0;
          error_d  = 1'b0;
          probe_d  = WIDTH'(1) << (WIDTH - 1);
          bit_d    = BIT_W'(WIDTH - 1);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) state_d = DECIDE;
      end
      DECIDE: begin
        if (!valid_c) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (is_eq_c) begin
          result_d = probe_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          // gt keeps the trial bit already set in the probe; lt drops it.
          res_upd  = is_gt_c ? probe_q : result_q;
          result_d = res_upd;
          if (bit_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            probe_d = res_upd | (WIDTH'(1) << (bit_q - BIT_W'(1)));
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign probe_out = probe_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_comparator_sar_search.sv
// Directed bench for comparator_sar_search with a behavioural 4-bit comparator on A.
module tb_comparator_sar_search;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic [3:0] a1, a3;
  logic       force_en;
  logic [5:0] flags1, flags3;
  logic [3:0] probe1, probe3, result1, result3;
  logic       busy1, busy3, done1, done3, error1, error3;

  int total = 0;
  int bad   = 0;

  function automatic logic [5:0] cmp_flags(input logic [3:0] a, input logic [3:0] b);
    cmp_flags = {a == b, a != b, a > b, a < b, a >= b, a <= b};
  endfunction

  // Probes needed: stops at the lowest set bit of A, or all bits when A is zero.
  function automatic int exp_probes(input logic [3:0] a);
    exp_probes = 4;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) begin
        exp_probes = 4 - i;
        break;
      end
    end
  endfunction

  assign flags1 = force_en ? 6'b000000 : cmp_flags(a1, probe1);
  assign flags3 = cmp_flags(a3, probe3);

  comparator_sar_search #(.WIDTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .flags_in(flags1),
    .probe_out(probe1), .busy(busy1), .done(done1), .result(result1), .error(error1)
  );

  comparator_sar_search #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .flags_in(flags3),
    .probe_out(probe3), .busy(busy3), .done(done3), .result(result3), .error(error3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one search, log the distinct probe values, return edges from accept to done.
  task automatic run_search(input bit s3, input logic [3:0] a, input bit hammer,
                            output int lat, output logic [15:0] seq, output int np);
    logic [3:0] p, last;
    lat = 0;
    seq = '0;
    np  = 0;
    if (s3) begin a3 = a; start3 = 1'b1; end
    else    begin a1 = a; start1 = 1'b1; end
    @(posedge clk); #1;
    if (!hammer) begin start1 = 1'b0; start3 = 1'b0; end
    check("busy_accept", 32'(s3 ? busy3 : busy1), 32'(1));
    check("err_clr_accept", 32'(s3 ? error3 : error1), 32'(0));
    p    = s3 ? probe3 : probe1;
    seq  = {seq[11:0], p};
    np   = 1;
    last = p;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (s3 ? done3 : done1) begin
        lat = n;
        break;
      end
      p = s3 ? probe3 : probe1;
      if (p != last) begin
        seq  = {seq[11:0], p};
        np   = np + 1;
        last = p;
      end
    end
    start1 = 1'b0;
    start3 = 1'b0;
    check("done_seen", 32'(lat != 0), 32'(1));
    check("busy_in_done", 32'(s3 ? busy3 : busy1), 32'(1));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(s3 ? done3 : done1), 32'(0));
    check("busy_after_done", 32'(s3 ? busy3 : busy1), 32'(0));
  endtask

  int          lat, np;
  logic [15:0] seq;
  logic        seen_done;

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; a1 = '0; a3 = '0; force_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_probe", 32'(probe1), 32'(0));
    check("rst_result", 32'(result1), 32'(0));
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_done", 32'(done1), 32'(0));
    check("rst_error", 32'(error1), 32'(0));
    check("rst3_all", 32'({probe3, result3, busy3, done3, error3}), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // A=1011: four probes, eq on the last
    run_search(1'b0, 4'b1011, 1'b0, lat, seq, np);
    check("a1011_lat", 32'(lat), 32'(8));
    check("a1011_probes", 32'(seq), 32'(16'b1000_1100_1010_1011));
    check("a1011_result", 32'(result1), 32'(4'b1011));
    check("a1011_error", 32'(error1), 32'(0));

    // A=1000: first probe hits eq
    run_search(1'b0, 4'b1000, 1'b0, lat, seq, np);
    check("a1000_lat", 32'(lat), 32'(2));
    check("a1000_nprobe", 32'(np), 32'(1));
    check("a1000_result", 32'(result1), 32'(4'b1000));

    // A=0000: never eq, all lt
    run_search(1'b0, 4'b0000, 1'b0, lat, seq, np);
    check("a0000_lat", 32'(lat), 32'(8));
    check("a0000_probes", 32'(seq), 32'(16'b1000_0100_0010_0001));
    check("a0000_result", 32'(result1), 32'(0));
    check("a0000_error", 32'(error1), 32'(0));

    // Inconsistent flags at the first sample
    force_en = 1'b1;
    run_search(1'b0, 4'b1011, 1'b0, lat, seq, np);
    force_en = 1'b0;
    check("bad_lat", 32'(lat), 32'(2));
    check("bad_error", 32'(error1), 32'(1));
    check("bad_result", 32'(result1), 32'(0));
    run_search(1'b0, 4'b0101, 1'b0, lat, seq, np);
    check("recover_error", 32'(error1), 32'(0));
    check("recover_result", 32'(result1), 32'(4'b0101));
    check("recover_lat", 32'(lat), 32'(8));

    // Reset three edges into a search
    a1 = 4'b0110; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_probe", 32'(probe1), 32'(0));
    check("midrst_busy", 32'(busy1), 32'(0));
    check("midrst_result_err_done", 32'({result1, error1, done1}), 32'(0));
    seen_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen_done = seen_done | done1; end
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen_done = seen_done | done1 | busy1; end
    check("midrst_no_done", 32'(seen_done), 32'(0));
    run_search(1'b0, 4'b0110, 1'b1, lat, seq, np);
    check("restart_lat", 32'(lat), 32'(6));
    check("restart_probes", 32'(seq), 32'(16'b0000_1000_0100_0110));
    check("restart_result", 32'(result1), 32'(4'b0110));
    check("restart_error", 32'(error1), 32'(0));

    // Full sweep at SETTLE=1 and SETTLE=3
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 16; v++) begin
        run_search(s == 1, 4'(v), 1'b0, lat, seq, np);
        check($sformatf("sweep_s%0d_a%0d_result", s, v), 32'(s == 1 ? result3 : result1), 32'(v));
        check($sformatf("sweep_s%0d_a%0d_error", s, v), 32'(s == 1 ? error3 : error1), 32'(0));
        check($sformatf("sweep_s%0d_a%0d_lat", s, v), 32'(lat),
              32'(exp_probes(4'(v)) * (s == 1 ? 4 : 2)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
